// File: rtl/key_evt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : key_evt_pkg
// Brief    : Shared event codes, gesture FSM encodings and ms-counter type
//            for the key event controller.
// Revision : 1.0 - initial release
// ============================================================================
package key_evt_pkg;

    localparam int CNT_W = 16;

    typedef logic [CNT_W-1:0] ms_cnt_t;
    typedef logic [2:0]       evt_code_t;

    localparam evt_code_t EVT_NONE   = 3'd0;
    localparam evt_code_t EVT_SHORT  = 3'd1;
    localparam evt_code_t EVT_DOUBLE = 3'd2;
    localparam evt_code_t EVT_LONG   = 3'd3;
    localparam evt_code_t EVT_REPEAT = 3'd4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DOWN1 = 3'd1;
    localparam logic [2:0] ST_HOLD  = 3'd2;
    localparam logic [2:0] ST_GAP   = 3'd3;
    localparam logic [2:0] ST_DOWN2 = 3'd4;

    // Saturating increment so a key parked in one state never wraps back to a match.
    function automatic ms_cnt_t ms_cnt_next(input ms_cnt_t cnt, input logic tick);
        return (tick && (cnt != '1)) ? cnt + ms_cnt_t'(1) : cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_evt_fsm.sv
`default_nettype none
// ============================================================================
// Module   : key_evt_fsm
// Brief    : Per-key edge detect, ms counter, gesture FSM and 1-entry event slot.
// Revision : 1.0 - initial release
// ============================================================================
module key_evt_fsm
    import key_evt_pkg::*;
#(
    parameter int LONG_MS   = 1000,
    parameter int DBL_MS    = 250,
    parameter int REPEAT_MS = 200
) (
    input  logic       sys_clk,
    input  logic       rst_in,
    input  logic       ms_tick_i,
    input  logic       key_i,
    input  logic       clear_i,
    output logic       pending_o,
    output logic [2:0] code_o,
    output logic       drop_o
);

    logic       key_prev_q;
    logic [2:0] state_q, state_d;
    ms_cnt_t    cnt_q, cnt_d;
    logic       pend_q, pend_d;
    evt_code_t  code_q, code_d;

    logic       rise, fall;
    logic       emit, restart;
    evt_code_t  emit_code;

    assign rise = key_i & ~key_prev_q;
    assign fall = ~key_i & key_prev_q;

    // Release takes priority over a same-cycle timer match in DOWN1 and HOLD.
    always_comb begin
        state_d   = state_q;
        emit      = 1'b0;
        emit_code = EVT_NONE;
        restart   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise) state_d = ST_DOWN1;
            end
            ST_DOWN1: begin
                if (fall) begin
                    state_d = ST_GAP;
                end else if (cnt_q == ms_cnt_t'(LONG_MS)) begin
                    emit      = 1'b1;
                    emit_code = EVT_LONG;
                    state_d   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (fall) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == ms_cnt_t'(REPEAT_MS)) begin
                    emit      = 1'b1;
                    emit_code = EVT_REPEAT;
                    restart   = 1'b1;
                end
            end
            ST_GAP: begin
                if (rise) begin
                    state_d = ST_DOWN2;
                end else if (cnt_q == ms_cnt_t'(DBL_MS)) begin
                    emit      = 1'b1;
                    emit_code = EVT_SHORT;
                    state_d   = ST_IDLE;
                end
            end
            ST_DOWN2: begin
                if (fall) begin
                    emit      = 1'b1;
                    emit_code = EVT_DOUBLE;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        if ((state_d != state_q) || restart) begin
            cnt_d = '0;
        end else begin
            cnt_d = ms_cnt_next(cnt_q, ms_tick_i);
        end
    end

    // A slot still holding an event (even one being drained this cycle) rejects new ones.
    always_comb begin
        pend_d = pend_q;
        code_d = code_q;
        if (clear_i) pend_d = 1'b0;
        if (emit && !pend_q) begin
            pend_d = 1'b1;
            code_d = emit_code;
        end
    end

    assign drop_o    = emit & pend_q;
    assign pending_o = pend_q;
    assign code_o    = code_q;

    always_ff @(posedge sys_clk or negedge rst_in) begin
        if (!rst_in) begin
            key_prev_q <= 1'b0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            code_q     <= EVT_NONE;
        end else begin
            key_prev_q <= key_i;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            code_q     <= code_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/key_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : key_event_ctrl
// Brief    : Gesture classifier for NUM_KEYS keys with round-robin merge into
//            a valid/ready event FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module key_event_ctrl
    import key_evt_pkg::*;
#(
    parameter int NUM_KEYS   = 4,
    parameter int CLK_PER_MS = 27000,
    parameter int LONG_MS    = 1000,
    parameter int DBL_MS     = 250,
    parameter int REPEAT_MS  = 200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        sys_clk,
    input  logic                        rst_in,
    input  logic [NUM_KEYS-1:0]         key_state,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [2:0]                  evt_code,
    output logic [$clog2(NUM_KEYS)-1:0] evt_key,
    output logic                        evt_overflow
);

    localparam int KW = $clog2(NUM_KEYS);
    localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic          ms_tick;

    assign ms_tick = (presc_q == PW'(CLK_PER_MS - 1));
    assign presc_d = ms_tick ? '0 : presc_q + PW'(1);

    logic [NUM_KEYS-1:0] slot_pend, slot_drop, slot_clr;
    evt_code_t           slot_code [NUM_KEYS];

    logic                push, pop;
    logic                grant_vld_q;
    logic [KW-1:0]       grant_key_q;
    evt_code_t           grant_code_q;

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            assign slot_clr[gi] = push & (grant_key_q == KW'(gi));

            key_evt_fsm #(
                .LONG_MS   (LONG_MS),
                .DBL_MS    (DBL_MS),
                .REPEAT_MS (REPEAT_MS)
            ) u_fsm (
                .sys_clk   (sys_clk),
                .rst_in    (rst_in),
                .ms_tick_i (ms_tick),
                .key_i     (key_state[gi]),
                .clear_i   (slot_clr[gi]),
                .pending_o (slot_pend[gi]),
                .code_o    (slot_code[gi]),
                .drop_o    (slot_drop[gi])
            );
        end
    endgenerate

    // One grant in flight at a time keeps full_q exact at selection time.
    logic          sel_vld;
    logic [KW-1:0] sel_idx;
    logic [KW-1:0] cand_idx;
    logic [KW-1:0] rr_q, rr_d;
    logic          full_q, full_d;

    always_comb begin
        sel_vld  = 1'b0;
        sel_idx  = '0;
        cand_idx = '0;
        if (!grant_vld_q && !full_q) begin
            for (int off = 0; off < NUM_KEYS; off++) begin
                cand_idx = KW'((int'(rr_q) + off) % NUM_KEYS);
                if (!sel_vld && slot_pend[cand_idx]) begin
                    sel_vld = 1'b1;
                    sel_idx = cand_idx;
                end
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (sel_vld) begin
            rr_d = (sel_idx == KW'(NUM_KEYS - 1)) ? '0 : sel_idx + KW'(1);
        end
    end

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    evt_code_t     code_mem [FIFO_DEPTH];
    logic [KW-1:0] key_mem  [FIFO_DEPTH];

    assign evt_valid = (count_q != '0);
    assign push      = grant_vld_q & ~full_q;
    assign pop       = evt_valid & evt_ready;
    assign evt_code  = evt_valid ? code_mem[rd_ptr_q] : EVT_NONE;
    assign evt_key   = evt_valid ? key_mem[rd_ptr_q]  : '0;

    always_comb begin
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        full_d = (count_d == (AW+1)'(FIFO_DEPTH));
    end

    always_ff @(posedge sys_clk) begin
        if (push) begin
            code_mem[wr_ptr_q] <= grant_code_q;
            key_mem[wr_ptr_q]  <= grant_key_q;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_in) begin
        if (!rst_in) begin
            presc_q      <= '0;
            rr_q         <= '0;
            grant_vld_q  <= 1'b0;
            grant_key_q  <= '0;
            grant_code_q <= EVT_NONE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            evt_overflow <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            rr_q         <= rr_d;
            grant_vld_q  <= sel_vld;
            if (sel_vld) begin
                grant_key_q  <= sel_idx;
                grant_code_q <= slot_code[sel_idx];
            end
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q      <= count_d;
            full_q       <= full_d;
            evt_overflow <= |slot_drop;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_key_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_event_ctrl
// Brief    : Directed self-checking bench for key_event_ctrl (fast timebase).
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_event_ctrl;

    logic       sys_clk;
    logic       rst_in;
    logic [3:0] key_state;
    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] evt_code;
    logic [1:0] evt_key;
    logic       evt_overflow;

    int total = 0;
    int bad   = 0;
    int ovf_cnt = 0;
    logic [2:0] got_code [$];
    logic [1:0] got_key  [$];

    key_event_ctrl #(
        .NUM_KEYS   (4),
        .CLK_PER_MS (10),
        .LONG_MS    (20),
        .DBL_MS     (5),
        .REPEAT_MS  (4),
        .FIFO_DEPTH (4)
    ) dut (
        .sys_clk      (sys_clk),
        .rst_in       (rst_in),
        .key_state    (key_state),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_code     (evt_code),
        .evt_key      (evt_key),
        .evt_overflow (evt_overflow)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Accepted events and overflow pulses are logged mid-cycle.
    always @(negedge sys_clk) begin
        if (rst_in && evt_valid && evt_ready) begin
            got_code.push_back(evt_code);
            got_key.push_back(evt_key);
        end
        if (evt_overflow) ovf_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_evt(input string tag, input int idx, input int code, input int key);
        logic [31:0] c, k;
        if (idx < got_code.size()) begin
            c = 32'(got_code[idx]);
            k = 32'(got_key[idx]);
        end else begin
            c = '1;
            k = '1;
        end
        chk({tag, "_code"}, c, code);
        chk({tag, "_key"}, k, key);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    int base;
    int obase;
    int lat;

    initial begin
        rst_in    = 1'b0;
        key_state = 4'b0000;
        evt_ready = 1'b1;
        step(3);
        chk("rst_valid", evt_valid, 0);
        chk("rst_code", evt_code, 0);
        chk("rst_key", evt_key, 0);
        chk("rst_ovf", evt_overflow, 0);
        rst_in = 1'b1;
        step(2);

        // Four simultaneous SHORTs, rr at 0
        base = got_code.size();
        key_state = 4'b1111;
        step(30);
        key_state = 4'b0000;
        step(100);
        chk("a_count", got_code.size() - base, 4);
        chk_evt("a0", base + 0, 1, 0);
        chk_evt("a1", base + 1, 1, 1);
        chk_evt("a2", base + 2, 1, 2);
        chk_evt("a3", base + 3, 1, 3);

        // Single SHORT on key0 with latency window from release
        base = got_code.size();
        key_state = 4'b0001;
        step(50);
        key_state = 4'b0000;
        lat = 0;
        for (int n = 1; (n <= 200) && (lat == 0); n++) begin
            @(negedge sys_clk);
            if (evt_valid) lat = n;
        end
        chk("b_latency_in_window", (lat >= 46 && lat <= 55), 1);
        step(20);
        chk("b_count", got_code.size() - base, 1);
        chk_evt("b0", base, 1, 0);

        // DOUBLE on key1, no SHORT
        base = got_code.size();
        key_state = 4'b0010;
        step(30);
        key_state = 4'b0000;
        step(20);
        key_state = 4'b0010;
        step(30);
        key_state = 4'b0000;
        step(100);
        chk("c_count", got_code.size() - base, 1);
        chk_evt("c0", base, 2, 1);

        // Simultaneous SHORTs again, rr now 2
        base = got_code.size();
        key_state = 4'b1111;
        step(30);
        key_state = 4'b0000;
        step(100);
        chk("d_count", got_code.size() - base, 4);
        chk_evt("d0", base + 0, 1, 2);
        chk_evt("d1", base + 1, 1, 3);
        chk_evt("d2", base + 2, 1, 0);
        chk_evt("d3", base + 3, 1, 1);

        // Key2 held 330 cycles: LONG then three REPEATs, nothing on release
        base = got_code.size();
        key_state = 4'b0100;
        step(330);
        key_state = 4'b0000;
        step(100);
        chk("e_count", got_code.size() - base, 4);
        chk_evt("e0", base + 0, 3, 2);
        chk_evt("e1", base + 1, 4, 2);
        chk_evt("e2", base + 2, 4, 2);
        chk_evt("e3", base + 3, 4, 2);

        // Back-pressure: six events from key3, FIFO 4 + slot 1, sixth dropped
        evt_ready = 1'b0;
        base  = got_code.size();
        obase = ovf_cnt;
        key_state = 4'b1000;
        step(415);
        key_state = 4'b0000;
        step(20);
        chk("f_valid_held", evt_valid, 1);
        chk("f_head_code", evt_code, 3);
        chk("f_head_key", evt_key, 3);
        chk("f_ovf_pulses", ovf_cnt - obase, 1);
        chk("f_none_taken", got_code.size() - base, 0);
        evt_ready = 1'b1;
        step(30);
        chk("f_drain_count", got_code.size() - base, 5);
        chk_evt("f0", base + 0, 3, 3);
        chk_evt("f1", base + 1, 4, 3);
        chk_evt("f2", base + 2, 4, 3);
        chk_evt("f3", base + 3, 4, 3);
        chk_evt("f4", base + 4, 4, 3);
        chk("f_ovf_after", ovf_cnt - obase, 1);

        // Reset with three queued events and key0 in GAP
        evt_ready = 1'b0;
        key_state = 4'b1000;
        step(290);
        key_state = 4'b0000;
        step(5);
        key_state = 4'b0001;
        step(5);
        key_state = 4'b0000;
        step(5);
        chk("g_valid_before", evt_valid, 1);
        rst_in = 1'b0;
        #1;
        chk("g_valid_in_rst", evt_valid, 0);
        step(2);
        rst_in    = 1'b1;
        evt_ready = 1'b1;
        base  = got_code.size();
        obase = ovf_cnt;
        step(100);
        chk("g_no_stale", got_code.size() - base, 0);
        chk("g_no_ovf", ovf_cnt - obase, 0);
        chk("g_valid_after", evt_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
